// File: rtl/ram_1r2w_wr_sched.sv
// ram_1r2w_wr_sched
// -----------------
// Write scheduler in front of a RAM with one read port and two write ports.
// Three requesters compete for the two write ports. A round-robin scan picks
// at most two requests per cycle. The first grant goes to write port 0 and
// the second to write port 1. Two writes to the same address are never
// issued in the same cycle.
//
// After reset, and after any clear_i, the whole RAM is filled with INIT_VAL.
// This takes two entries per cycle (INIT state). Requests are accepted only
// in RUN state.
//
// Handshake: a requester transfers on a cycle when req_valid_i[n] and
// req_ready_o[n] are both high at the rising edge. req_ready_o is decided
// combinationally from valid, addresses, state and the round-robin pointer.
// It never depends on itself. A requester that is not granted is simply
// re-evaluated on the next cycle.
//
// Optional feature (macro RAM_1R2W_SCHED_BYPASS_EN):
//   defined   - rd_data_o forwards a registered write that hits rd_addr_i.
//               Port 1 takes priority over port 0.
//   undefined - rd_data_o is ram_rdata_i.
//
// Ports
//   clk, reset                   clock, asynchronous active-low reset
//   clear_i                      re-initialise the whole RAM
//   req_valid_i/addr_i/data_i    three packed write requesters
//   req_ready_o                  per-requester grant
//   we0_o/addr0wr_o/data0wr_o    registered RAM write port 0
//   we1_o/addr1wr_o/data1wr_o    registered RAM write port 1
//   rd_addr_i -> addr0_o         read address, passed straight through
//   ram_rdata_i -> rd_data_o     read data, optionally with write forwarding
//   init_done_o                  high only in RUN
//   dbg_state_o                  FSM state (0 = INIT, 1 = RUN)
module ram_1r2w_wr_sched #(
  parameter int               DEPTH    = 16,
  parameter int               INDEX    = 4,
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic [2:0]         req_valid_i,
  input  logic [3*INDEX-1:0] req_addr_i,
  input  logic [3*WIDTH-1:0] req_data_i,
  output logic [2:0]         req_ready_o,
  output logic               we0_o,
  output logic [INDEX-1:0]   addr0wr_o,
  output logic [WIDTH-1:0]   data0wr_o,
  output logic               we1_o,
  output logic [INDEX-1:0]   addr1wr_o,
  output logic [WIDTH-1:0]   data1wr_o,
  input  logic [INDEX-1:0]   rd_addr_i,
  output logic [INDEX-1:0]   addr0_o,
  input  logic [WIDTH-1:0]   ram_rdata_i,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic               init_done_o,
  output logic               dbg_state_o
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [INDEX-1:0] cnt_q, cnt_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic             we0_q, we0_d, we1_q, we1_d;
  logic [INDEX-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;

  // Unpacked views of the requester buses. Entry 3 is a dummy, so a 2-bit
  // index always lands inside the array.
  logic [INDEX-1:0] addr_a [4];
  logic [WIDTH-1:0] data_a [4];

  logic [2:0] grant;
  logic       first_found, second_found;
  logic [1:0] first_idx, second_idx, scan_idx;

  // (ptr + off) mod 3, for ptr and off in 0..2
  function automatic logic [1:0] rr_next(input logic [1:0] ptr, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      addr_a[i] = req_addr_i[i*INDEX +: INDEX];
      data_a[i] = req_data_i[i*WIDTH +: WIDTH];
    end
    addr_a[3] = '0;
    data_a[3] = '0;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    we0_d        = 1'b0;
    addr0_d      = '0;
    data0_d      = '0;
    we1_d        = 1'b0;
    addr1_d      = '0;
    data1_d      = '0;
    grant        = 3'b000;
    first_found  = 1'b0;
    second_found = 1'b0;
    first_idx    = 2'd0;
    second_idx   = 2'd0;
    scan_idx     = 2'd0;

    unique case (state_q)
      ST_INIT: begin
        we0_d   = 1'b1;
        addr0_d = cnt_q;
        data0_d = INIT_VAL;
        we1_d   = 1'b1;
        addr1_d = cnt_q + INDEX'(1);
        data1_d = INIT_VAL;
        if (clear_i) begin
          cnt_d = '0;
        end else if (cnt_q == INDEX'(DEPTH - 2)) begin
          // Last pair goes out this cycle. RUN starts on the next edge.
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + INDEX'(2);
        end
      end

      ST_RUN: begin
        if (clear_i) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          // Scan in round-robin order. A candidate that collides with the
          // first grant's address is skipped. A later candidate can still
          // take port 1.
          for (int i = 0; i < 3; i++) begin
            scan_idx = rr_next(rr_ptr_q, 2'(i));
            if (req_valid_i[scan_idx]) begin
              if (!first_found) begin
                first_found = 1'b1;
                first_idx   = scan_idx;
              end else if (!second_found && (addr_a[scan_idx] != addr_a[first_idx])) begin
                second_found = 1'b1;
                second_idx   = scan_idx;
              end
            end
          end

          if (first_found) begin
            grant    = grant | (3'b001 << first_idx);
            we0_d    = 1'b1;
            addr0_d  = addr_a[first_idx];
            data0_d  = data_a[first_idx];
            rr_ptr_d = rr_next(first_idx, 2'd1);
          end
          if (second_found) begin
            grant    = grant | (3'b001 << second_idx);
            we1_d    = 1'b1;
            addr1_d  = addr_a[second_idx];
            data1_d  = data_a[second_idx];
            rr_ptr_d = rr_next(second_idx, 2'd1);
          end
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      rr_ptr_q <= 2'd0;
      we0_q    <= 1'b0;
      addr0_q  <= '0;
      data0_q  <= '0;
      we1_q    <= 1'b0;
      addr1_q  <= '0;
      data1_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      we0_q    <= we0_d;
      addr0_q  <= addr0_d;
      data0_q  <= data0_d;
      we1_q    <= we1_d;
      addr1_q  <= addr1_d;
      data1_q  <= data1_d;
    end
  end

  assign req_ready_o = grant;
  assign we0_o       = we0_q;
  assign addr0wr_o   = addr0_q;
  assign data0wr_o   = data0_q;
  assign we1_o       = we1_q;
  assign addr1wr_o   = addr1_q;
  assign data1wr_o   = data1_q;
  assign addr0_o     = rd_addr_i;
  assign init_done_o = (state_q == ST_RUN);
  assign dbg_state_o = state_q;

`ifdef RAM_1R2W_SCHED_BYPASS_EN
  // The RAM has not absorbed the registered writes yet. Port 1 is newer in
  // scan order, so it wins. Its address never equals port 0's anyway.
  always_comb begin
    rd_data_o = ram_rdata_i;
    if (we1_q && (addr1_q == rd_addr_i)) begin
      rd_data_o = data1_q;
    end else if (we0_q && (addr0_q == rd_addr_i)) begin
      rd_data_o = data0_q;
    end
  end
`else
  assign rd_data_o = ram_rdata_i;
`endif

endmodule

// File: tb/tb_ram_1r2w_wr_sched.sv
module tb_ram_1r2w_wr_sched;

  localparam int               DEPTH    = 16;
  localparam int               INDEX    = 4;
  localparam int               WIDTH    = 8;
  localparam logic [WIDTH-1:0] INIT_VAL = 8'h00;
  // {skip, we0, addr0, data0, we1, addr1, data1}
  localparam int               W        = 1 + 2 * (1 + INDEX + WIDTH);

  logic               clk = 1'b0;
  logic               reset;
  logic               clear_i;
  logic [2:0]         req_valid_i;
  logic [3*INDEX-1:0] req_addr_i;
  logic [3*WIDTH-1:0] req_data_i;
  logic [2:0]         req_ready_o;
  logic               we0_o, we1_o;
  logic [INDEX-1:0]   addr0wr_o, addr1wr_o;
  logic [WIDTH-1:0]   data0wr_o, data1wr_o;
  logic [INDEX-1:0]   rd_addr_i, addr0_o;
  logic [WIDTH-1:0]   ram_rdata_i, rd_data_o;
  logic               init_done_o;
  logic               dbg_state_o;

  ram_1r2w_wr_sched #(
    .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .INIT_VAL(INIT_VAL)
  ) dut (
    .clk(clk), .reset(reset), .clear_i(clear_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .we0_o(we0_o), .addr0wr_o(addr0wr_o), .data0wr_o(data0wr_o),
    .we1_o(we1_o), .addr1wr_o(addr1wr_o), .data1wr_o(data1wr_o),
    .rd_addr_i(rd_addr_i), .addr0_o(addr0_o),
    .ram_rdata_i(ram_rdata_i), .rd_data_o(rd_data_o),
    .init_done_o(init_done_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp, sb_obs;
  logic         sb_en = 1'b0;
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic logic [W-1:0] mk_w(input logic skip,
                                        input logic we0, input logic [INDEX-1:0] a0, input logic [WIDTH-1:0] d0,
                                        input logic we1, input logic [INDEX-1:0] a1, input logic [WIDTH-1:0] d1);
    return {skip, we0, (we0 ? a0 : '0), (we0 ? d0 : '0), we1, (we1 ? a1 : '0), (we1 ? d1 : '0)};
  endfunction

  // One expected entry per clock edge while enabled, popped 2 time units
  // after the edge that registers it.
  always @(posedge clk) begin
    #2;
    if (sb_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got no expected entry, required one per cycle");
      end else begin
        sb_exp = exp_q.pop_front();
        if (!sb_exp[W-1]) begin
          sb_obs = mk_w(1'b0, we0_o, addr0wr_o, data0wr_o, we1_o, addr1wr_o, data1wr_o);
          n_checks++;
          if (sb_obs !== sb_exp) begin
            n_fail++;
            $display("FAIL sb_write @%0t: got %h required %h", $time, sb_obs, sb_exp);
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_req(input int i, input logic v, input logic [INDEX-1:0] a, input logic [WIDTH-1:0] d);
    req_valid_i[i]              = v;
    req_addr_i[i*INDEX +: INDEX] = a;
    req_data_i[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic drive_idle();
    clear_i     = 1'b0;
    req_valid_i = 3'b000;
    req_addr_i  = '0;
    req_data_i  = '0;
    rd_addr_i   = '0;
    ram_rdata_i = '0;
  endtask

  // Hold reset, then release it between edges so that the next edge is
  // the first INIT edge.
  task automatic do_reset();
    sb_en = 1'b0;
    exp_q.delete();
    reset = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    sb_en = 1'b1;
  endtask

  // DEPTH/2 INIT cycles, issuing pair (2k, 2k+1), with no grant.
  task automatic walk_init(input logic [2:0] valids, input string tag);
    for (int k = 0; k < DEPTH/2; k++) begin
      @(negedge clk);
      clear_i     = 1'b0;
      req_valid_i = valids;
      #1;
      n_checks++;
      if (init_done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_done_low k=%0d: got %b required 0", tag, k, init_done_o);
      end
      n_checks++;
      if (req_ready_o !== 3'b000) begin
        n_fail++;
        $display("FAIL %s_ready_zero k=%0d: got %b required 000", tag, k, req_ready_o);
      end
      exp_q.push_back(mk_w(1'b0, 1'b1, INDEX'(2*k), INIT_VAL, 1'b1, INDEX'(2*k+1), INIT_VAL));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset_state();
    reset = 1'b1;
    drive_idle();
    req_valid_i = 3'b111;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({we0_o, we1_o, addr0wr_o, addr1wr_o, data0wr_o, data1wr_o, init_done_o, req_ready_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b%b a=%h/%h d=%h/%h done=%b rdy=%b required all 0",
               we0_o, we1_o, addr0wr_o, addr1wr_o, data0wr_o, data1wr_o, init_done_o, req_ready_o);
    end
    do_reset();
  endtask

  task automatic test_init();
    walk_init(3'b111, "init");
    @(negedge clk);
    req_valid_i = 3'b000;
    #1;
    n_checks++;
    if (init_done_o !== 1'b1 || dbg_state_o !== 1'b1) begin
      n_fail++;
      $display("FAIL init_done_high: got done=%b state=%b required 1/1", init_done_o, dbg_state_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b0, '0, '0, 1'b0, '0, '0));
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    set_req(0, 1'b1, 4'd3, 8'h11);
    set_req(1, 1'b1, 4'd5, 8'h22);
    set_req(2, 1'b1, 4'd7, 8'h33);
    #1;
    n_checks++;
    if (req_ready_o !== 3'b011) begin
      n_fail++;
      $display("FAIL rr_first: got %b required 011", req_ready_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b1, 4'd3, 8'h11, 1'b1, 4'd5, 8'h22));

    @(negedge clk);
    set_req(0, 1'b1, 4'd8, 8'h44);
    set_req(1, 1'b0, 4'd0, 8'h00);
    #1;
    n_checks++;
    if (req_ready_o !== 3'b101) begin
      n_fail++;
      $display("FAIL rr_second: got %b required 101", req_ready_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b1, 4'd7, 8'h33, 1'b1, 4'd8, 8'h44));

    @(negedge clk);
    set_req(0, 1'b1, 4'd10, 8'h55);
    set_req(1, 1'b1, 4'd12, 8'h66);
    set_req(2, 1'b1, 4'd14, 8'h77);
    #1;
    n_checks++;
    if (req_ready_o !== 3'b110) begin
      n_fail++;
      $display("FAIL rr_third: got %b required 110", req_ready_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b1, 4'd12, 8'h66, 1'b1, 4'd14, 8'h77));

    @(negedge clk);
    req_valid_i = 3'b000;
    #1;
    n_checks++;
    if (req_ready_o !== 3'b000) begin
      n_fail++;
      $display("FAIL rr_idle: got %b required 000", req_ready_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b0, '0, '0, 1'b0, '0, '0));
  endtask

  task automatic test_conflict();
    @(negedge clk);
    set_req(0, 1'b1, 4'd4, 8'hA1);
    set_req(1, 1'b1, 4'd4, 8'hB2);
    set_req(2, 1'b1, 4'd9, 8'hC3);
    #1;
    n_checks++;
    if (req_ready_o !== 3'b101) begin
      n_fail++;
      $display("FAIL conf_skip: got %b required 101", req_ready_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b1, 4'd4, 8'hA1, 1'b1, 4'd9, 8'hC3));

    @(negedge clk);
    req_valid_i = 3'b010;
    #1;
    n_checks++;
    if (req_ready_o !== 3'b010) begin
      n_fail++;
      $display("FAIL conf_late: got %b required 010", req_ready_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b1, 4'd4, 8'hB2, 1'b0, '0, '0));

    // All three on one address: one grant per cycle, in round-robin order
    @(negedge clk);
    set_req(0, 1'b1, 4'd2, 8'h01);
    set_req(1, 1'b1, 4'd2, 8'h02);
    set_req(2, 1'b1, 4'd2, 8'h03);
    #1;
    n_checks++;
    if (req_ready_o !== 3'b100) begin
      n_fail++;
      $display("FAIL conf_all_a: got %b required 100", req_ready_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b1, 4'd2, 8'h03, 1'b0, '0, '0));

    @(negedge clk);
    req_valid_i = 3'b011;
    #1;
    n_checks++;
    if (req_ready_o !== 3'b001) begin
      n_fail++;
      $display("FAIL conf_all_b: got %b required 001", req_ready_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b1, 4'd2, 8'h01, 1'b0, '0, '0));

    @(negedge clk);
    req_valid_i = 3'b010;
    #1;
    n_checks++;
    if (req_ready_o !== 3'b010) begin
      n_fail++;
      $display("FAIL conf_all_c: got %b required 010", req_ready_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b1, 4'd2, 8'h02, 1'b0, '0, '0));

    @(negedge clk);
    req_valid_i = 3'b000;
    exp_q.push_back(mk_w(1'b0, 1'b0, '0, '0, 1'b0, '0, '0));
  endtask

  task automatic test_clear();
    @(negedge clk);
    set_req(0, 1'b1, 4'd2, 8'h5A);
    clear_i = 1'b1;
    #1;
    n_checks++;
    if (req_ready_o !== 3'b000 || init_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_cycle: got rdy=%b done=%b required 000/1", req_ready_o, init_done_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b0, '0, '0, 1'b0, '0, '0));

    walk_init(3'b001, "clear");

    @(negedge clk);
    #1;
    n_checks++;
    if (init_done_o !== 1'b1 || req_ready_o !== 3'b001) begin
      n_fail++;
      $display("FAIL clear_resume: got done=%b rdy=%b required 1/001", init_done_o, req_ready_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b1, 4'd2, 8'h5A, 1'b0, '0, '0));

    @(negedge clk);
    req_valid_i = 3'b000;
    exp_q.push_back(mk_w(1'b0, 1'b0, '0, '0, 1'b0, '0, '0));
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] exp_rd;
    @(negedge clk);
    set_req(0, 1'b1, 4'd6, 8'hA5);
    exp_q.push_back(mk_w(1'b0, 1'b1, 4'd6, 8'hA5, 1'b0, '0, '0));

    @(negedge clk);
    req_valid_i = 3'b000;
    rd_addr_i   = 4'd6;
    ram_rdata_i = 8'h00;
    #1;
`ifdef RAM_1R2W_SCHED_BYPASS_EN
    exp_rd = 8'hA5;
`else
    exp_rd = 8'h00;
`endif
    n_checks++;
    if (rd_data_o !== exp_rd) begin
      n_fail++;
      $display("FAIL byp_port0: got %h required %h", rd_data_o, exp_rd);
    end
    n_checks++;
    if (addr0_o !== 4'd6) begin
      n_fail++;
      $display("FAIL rd_addr_pass: got %h required 6", addr0_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b0, '0, '0, 1'b0, '0, '0));

    @(negedge clk);
    set_req(1, 1'b1, 4'd3, 8'h22);
    set_req(2, 1'b1, 4'd6, 8'h33);
    exp_q.push_back(mk_w(1'b0, 1'b1, 4'd3, 8'h22, 1'b1, 4'd6, 8'h33));

    @(negedge clk);
    req_valid_i = 3'b000;
    rd_addr_i   = 4'd6;
    ram_rdata_i = 8'h5E;
    #1;
`ifdef RAM_1R2W_SCHED_BYPASS_EN
    exp_rd = 8'h33;
`else
    exp_rd = 8'h5E;
`endif
    n_checks++;
    if (rd_data_o !== exp_rd) begin
      n_fail++;
      $display("FAIL byp_port1: got %h required %h", rd_data_o, exp_rd);
    end
    rd_addr_i = 4'd3;
    #1;
`ifdef RAM_1R2W_SCHED_BYPASS_EN
    exp_rd = 8'h22;
`else
    exp_rd = 8'h5E;
`endif
    n_checks++;
    if (rd_data_o !== exp_rd) begin
      n_fail++;
      $display("FAIL byp_port0b: got %h required %h", rd_data_o, exp_rd);
    end
    rd_addr_i = 4'd9;
    #1;
    n_checks++;
    if (rd_data_o !== 8'h5E) begin
      n_fail++;
      $display("FAIL byp_miss: got %h required 5e", rd_data_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b0, '0, '0, 1'b0, '0, '0));
  endtask

  task automatic test_clear_in_init();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_q.push_back(mk_w(1'b0, 1'b1, INDEX'(2*k), INIT_VAL, 1'b1, INDEX'(2*k+1), INIT_VAL));
    end
    @(negedge clk);
    clear_i = 1'b1;
    exp_q.push_back(mk_w(1'b1, 1'b0, '0, '0, 1'b0, '0, '0));
    walk_init(3'b000, "cinit");
    @(negedge clk);
    #1;
    n_checks++;
    if (init_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cinit_done: got %b required 1", init_done_o);
    end
    exp_q.push_back(mk_w(1'b0, 1'b0, '0, '0, 1'b0, '0, '0));
  endtask

  task automatic test_reset_mid();
    // Mid-INIT, with cnt at 6
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_q.push_back(mk_w(1'b0, 1'b1, INDEX'(2*k), INIT_VAL, 1'b1, INDEX'(2*k+1), INIT_VAL));
    end
    @(negedge clk);
    sb_en = 1'b0;
    req_valid_i = 3'b111;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({we0_o, we1_o, addr0wr_o, addr1wr_o, data0wr_o, data1wr_o, init_done_o, req_ready_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_init: got we=%b%b a=%h/%h d=%h/%h done=%b rdy=%b required all 0",
               we0_o, we1_o, addr0wr_o, addr1wr_o, data0wr_o, data1wr_o, init_done_o, req_ready_o);
    end
    do_reset();
    walk_init(3'b000, "rst_init");

    // Mid-RUN, with a registered write pending
    @(negedge clk);
    sb_en = 1'b0;
    exp_q.delete();
    set_req(0, 1'b1, 4'd1, 8'h77);
    @(posedge clk);
    #1;
    n_checks++;
    if (we0_o !== 1'b1 || addr0wr_o !== 4'd1 || data0wr_o !== 8'h77) begin
      n_fail++;
      $display("FAIL rst_run_pre: got we0=%b a=%h d=%h required 1/1/77", we0_o, addr0wr_o, data0wr_o);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({we0_o, we1_o, addr0wr_o, addr1wr_o, data0wr_o, data1wr_o, init_done_o, req_ready_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_run: got we=%b%b a=%h/%h d=%h/%h done=%b rdy=%b required all 0",
               we0_o, we1_o, addr0wr_o, addr1wr_o, data0wr_o, data1wr_o, init_done_o, req_ready_o);
    end
    do_reset();
    walk_init(3'b000, "rst_run");
  endtask

  // Random traffic. Each requester holds its request until granted. The
  // expected grants come from a small independent round-robin model.
  logic             rv  [3];
  logic [INDEX-1:0] ra  [3];
  logic [WIDTH-1:0] rdd [3];

  task automatic test_random();
    int         mptr;
    int         f, s, p, g;
    logic [2:0] exp_rdy;
    for (int i = 0; i < 3; i++) begin
      rv[i]  = ($urandom_range(0, 3) != 0);
      ra[i]  = INDEX'($urandom_range(0, 3));
      rdd[i] = WIDTH'($urandom_range(0, 255));
    end
    mptr = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) set_req(i, rv[i], ra[i], rdd[i]);
      #1;
      g = 0; f = 0; s = 0;
      for (int j = 0; j < 3; j++) begin
        p = (mptr + j) % 3;
        if (rv[p] && g == 0) begin
          f = p; g = 1;
        end else if (rv[p] && g == 1 && ra[p] != ra[f]) begin
          s = p; g = 2;
        end
      end
      exp_rdy = 3'b000;
      if (g >= 1) exp_rdy[f] = 1'b1;
      if (g == 2) exp_rdy[s] = 1'b1;
      n_checks++;
      if (req_ready_o !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_ready c=%0d: got %b required %b", c, req_ready_o, exp_rdy);
      end
      exp_q.push_back(mk_w(1'b0, g >= 1, ra[f], rdd[f], g == 2, ra[s], rdd[s]));
      if (g == 2) mptr = (s + 1) % 3;
      else if (g == 1) mptr = (f + 1) % 3;
      for (int i = 0; i < 3; i++) begin
        if (exp_rdy[i] || !rv[i]) begin
          rv[i]  = ($urandom_range(0, 3) != 0);
          ra[i]  = INDEX'($urandom_range(0, 3));
          rdd[i] = WIDTH'($urandom_range(0, 255));
        end
      end
    end
    @(negedge clk);
    req_valid_i = 3'b000;
    exp_q.push_back(mk_w(1'b0, 1'b0, '0, '0, 1'b0, '0, '0));
    @(posedge clk);
    #3;
    sb_en = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset_state();
    test_init();
    test_round_robin();
    test_conflict();
    test_clear();
    test_bypass();
    test_clear_in_init();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
